// File: rtl/nrf_spi_arbiter.sv
// nrf_spi_arbiter: round-robin arbiter sharing one SPI master between two requesters.
// Owns chip-select timing (setup, hold, minimum high time) around each transaction.
// Optional idle-grant watchdog enabled by defining macro NRF_ARB_TIMEOUT_EN.
module nrf_spi_arbiter #(
    parameter int unsigned CS_SETUP_CYCLES = 2,
    parameter int unsigned CS_HOLD_CYCLES  = 2,
    parameter int unsigned CSN_HIGH_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Req_0,
    input  logic       i_TX_DV_0,
    input  logic [7:0] i_TX_Byte_0,
    input  logic       i_Last_0,
    input  logic       i_Req_1,
    input  logic       i_TX_DV_1,
    input  logic [7:0] i_TX_Byte_1,
    input  logic       i_Last_1,
    output logic       o_Gnt_0,
    output logic       o_TX_Ready_0,
    output logic       o_RX_DV_0,
    output logic       o_Gnt_1,
    output logic       o_TX_Ready_1,
    output logic       o_RX_DV_1,
    output logic [7:0] o_RX_Byte,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Ready,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_SPI_Csn,
    output logic       o_Busy,
    output logic       o_Timeout
);

    localparam int unsigned PHASE_W = 8;
    localparam int unsigned WD_W    = 16;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_GRANTED  = 3'd2;
    localparam logic [2:0] ST_XFER     = 3'd3;
    localparam logic [2:0] ST_CS_HOLD  = 3'd4;
    localparam logic [2:0] ST_CS_HIGH  = 3'd5;

    // Phase counters load N-1 on entry so each phase lasts exactly N clocks.
    localparam logic [PHASE_W-1:0] SETUP_LOAD = PHASE_W'(CS_SETUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(CS_HOLD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HIGH_LOAD  = PHASE_W'(CSN_HIGH_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         pend_q, pend_d;
    logic               last_q, last_d;
    logic               owner_q, owner_d;
    logic               tx_last_q, tx_last_d;
    logic               tx_dv_q, tx_dv_d;
    logic [BYTE_W-1:0]  tx_byte_q, tx_byte_d;
    logic [1:0]         rx_dv_q, rx_dv_d;
    logic [BYTE_W-1:0]  rx_byte_q, rx_byte_d;
    logic               csn_q, csn_d;
    logic               busy_q, busy_d;

`ifdef NRF_ARB_TIMEOUT_EN
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^WD_W'(TIMEOUT_CYCLES);
`endif

    logic [1:0]        req_eff;
    logic              winner;
    logic              tx_ready_c;
    logic              sel_dv;
    logic [BYTE_W-1:0] sel_byte;
    logic              sel_last;
    logic              accept;

    // Request view, round-robin winner and granted-requester byte mux.
    always_comb begin
        req_eff  = {i_Req_1, i_Req_0} | pend_q;
        winner   = (req_eff == 2'b11) ? ~last_q : req_eff[1];
        tx_ready_c = (state_q == ST_GRANTED) && i_TX_Ready;
        sel_dv   = owner_q ? i_TX_DV_1   : i_TX_DV_0;
        sel_byte = owner_q ? i_TX_Byte_1 : i_TX_Byte_0;
        sel_last = owner_q ? i_Last_1    : i_Last_0;
        accept   = tx_ready_c && sel_dv;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        gnt_d     = gnt_q;
        pend_d    = pend_q;
        last_d    = last_q;
        owner_d   = owner_q;
        tx_last_d = tx_last_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        rx_dv_d   = 2'b00;
        rx_byte_d = rx_byte_q;
`ifdef NRF_ARB_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = 1'b0;
`endif

        // Remember requests seen while the bus is busy so short pulses are not lost.
        if (state_q == ST_CS_HIGH) begin
            pend_d = pend_q | {i_Req_1, i_Req_0};
        end else if (state_q != ST_IDLE) begin
            if (owner_q) pend_d[0] = pend_q[0] | i_Req_0;
            else         pend_d[1] = pend_q[1] | i_Req_1;
        end

        case (state_q)
            ST_IDLE: begin
                if (|req_eff) begin
                    state_d = ST_CS_SETUP;
                    phase_d = SETUP_LOAD;
                    owner_d = winner;
                    gnt_d   = winner ? 2'b10 : 2'b01;
                    pend_d  = winner ? {1'b0, pend_q[0]} : {pend_q[1], 1'b0};
                end
            end
            ST_CS_SETUP: begin
                if (phase_q == '0) begin
                    state_d = ST_GRANTED;
`ifdef NRF_ARB_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            ST_GRANTED: begin
                if (accept) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = sel_byte;
                    tx_last_d = sel_last;
                    state_d   = ST_XFER;
                end
`ifdef NRF_ARB_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_CS_HOLD;
                    phase_d   = HOLD_LOAD;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            ST_XFER: begin
                if (i_RX_DV) begin
                    rx_byte_d = i_RX_Byte;
                    rx_dv_d   = gnt_q;
                    if (tx_last_q) begin
                        state_d = ST_CS_HOLD;
                        phase_d = HOLD_LOAD;
                    end else begin
                        state_d = ST_GRANTED;
`ifdef NRF_ARB_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end
                end
            end
            ST_CS_HOLD: begin
                if (phase_q == '0) begin
                    state_d = ST_CS_HIGH;
                    phase_d = HIGH_LOAD;
                    gnt_d   = 2'b00;
                    last_d  = owner_q;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            ST_CS_HIGH: begin
                if (phase_q == '0) state_d = ST_IDLE;
                else               phase_d = phase_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        csn_d  = !((state_d == ST_CS_SETUP) || (state_d == ST_GRANTED) ||
                   (state_d == ST_XFER)     || (state_d == ST_CS_HOLD));
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            gnt_q     <= 2'b00;
            pend_q    <= 2'b00;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            tx_last_q <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            rx_dv_q   <= 2'b00;
            rx_byte_q <= '0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
`ifdef NRF_ARB_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            gnt_q     <= gnt_d;
            pend_q    <= pend_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            tx_last_q <= tx_last_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            rx_dv_q   <= rx_dv_d;
            rx_byte_q <= rx_byte_d;
            csn_q     <= csn_d;
            busy_q    <= busy_d;
`ifdef NRF_ARB_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign o_Gnt_0      = gnt_q[0];
    assign o_Gnt_1      = gnt_q[1];
    // Ready follows the SPI master combinationally so a strobe is never offered against a busy master.
    assign o_TX_Ready_0 = tx_ready_c && gnt_q[0];
    assign o_TX_Ready_1 = tx_ready_c && gnt_q[1];
    assign o_RX_DV_0    = rx_dv_q[0];
    assign o_RX_DV_1    = rx_dv_q[1];
    assign o_RX_Byte    = rx_byte_q;
    assign o_TX_DV      = tx_dv_q;
    assign o_TX_Byte    = tx_byte_q;
    assign o_SPI_Csn    = csn_q;
    assign o_Busy       = busy_q;
`ifdef NRF_ARB_TIMEOUT_EN
    assign o_Timeout    = timeout_q;
`else
    assign o_Timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_nrf_spi_arbiter.sv
// Scoreboard bench for nrf_spi_arbiter: directed stimulus pushes expected events,
// a monitor pops and compares whenever the DUT presents one.
module tb_nrf_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_0, tx_dv_0, last_0, req_1, tx_dv_1, last_1;
    logic [7:0] tx_byte_0, tx_byte_1;
    logic       gnt_0, tx_ready_0, rx_dv_0, gnt_1, tx_ready_1, rx_dv_1;
    logic [7:0] rx_byte, tx_byte;
    logic       tx_dv, spi_tx_ready, spi_rx_dv, csn, busy, timeout;
    logic [7:0] spi_rx_byte;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] tx_q[$];
    logic [9:0] rx_q[$];
    logic [1:0] gnt_q[$];
    logic [1:0] to_q[$];
    logic [7:0] slave_q[$];

    always #5 clk = ~clk;

    nrf_spi_arbiter #(
        .CS_SETUP_CYCLES(2), .CS_HOLD_CYCLES(2), .CSN_HIGH_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_Req_0(req_0), .i_TX_DV_0(tx_dv_0), .i_TX_Byte_0(tx_byte_0), .i_Last_0(last_0),
        .i_Req_1(req_1), .i_TX_DV_1(tx_dv_1), .i_TX_Byte_1(tx_byte_1), .i_Last_1(last_1),
        .o_Gnt_0(gnt_0), .o_TX_Ready_0(tx_ready_0), .o_RX_DV_0(rx_dv_0),
        .o_Gnt_1(gnt_1), .o_TX_Ready_1(tx_ready_1), .o_RX_DV_1(rx_dv_1),
        .o_RX_Byte(rx_byte), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
        .i_TX_Ready(spi_tx_ready), .i_RX_DV(spi_rx_dv), .i_RX_Byte(spi_rx_byte),
        .o_SPI_Csn(csn), .o_Busy(busy), .o_Timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h with no event expected (t=%0t)", name, act, $time);
    endtask

    // Monitor: pops expected events as the DUT presents them, plus per-cycle invariants.
    initial begin
        logic [1:0] prev_g;
        logic [1:0] rise;
        logic [9:0] rx_act;
        prev_g = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_g = 2'b00;
            end else begin
                check("csn_gnt_invariant", {30'd0, csn, gnt_0 & gnt_1}, {30'd0, ~(gnt_0 | gnt_1), 1'b0});
                rise = {gnt_1, gnt_0} & ~prev_g;
                if (rise != 2'b00) begin
                    if (gnt_q.size() == 0) note_unexpected("gnt_event", {30'd0, rise});
                    else check("gnt_event", {30'd0, rise}, {30'd0, gnt_q.pop_front()});
                end
                prev_g = {gnt_1, gnt_0};
                if (tx_dv) begin
                    if (tx_q.size() == 0) note_unexpected("tx_event", {24'd0, tx_byte});
                    else check("tx_event", {24'd0, tx_byte}, {24'd0, tx_q.pop_front()});
                end
                if (rx_dv_0 || rx_dv_1) begin
                    rx_act = {rx_dv_1, rx_dv_0, rx_byte};
                    if (rx_q.size() == 0) note_unexpected("rx_event", {22'd0, rx_act});
                    else check("rx_event", {22'd0, rx_act}, {22'd0, rx_q.pop_front()});
                end
                if (timeout) begin
                    if (to_q.size() == 0) note_unexpected("timeout_event", {30'd0, gnt_1, gnt_0});
                    else check("timeout_event", {30'd0, gnt_1, gnt_0}, {30'd0, to_q.pop_front()});
                end
            end
        end
    end

    // SPI slave model: answers each TX byte three clocks later with the next queued response.
    initial begin
        logic [7:0] resp;
        spi_rx_dv = 1'b0;
        spi_rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && tx_dv) begin
                resp = (slave_q.size() != 0) ? slave_q.pop_front() : 8'h00;
                repeat (3) @(negedge clk);
                spi_rx_dv = 1'b1;
                spi_rx_byte = resp;
                @(negedge clk);
                spi_rx_dv = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1, "time limit");
    end

    function automatic logic ready_of(input int id);
        return (id == 0) ? tx_ready_0 : tx_ready_1;
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input int id, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!((id == 0) ? gnt_0 : gnt_1) && cnt < 200);
        if (cnt >= 200) note_unexpected("wait_gnt_expired", 32'(id));
    endtask

    task automatic wait_ready(input int id);
        int cnt = 0;
        while (!ready_of(id) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) note_unexpected("wait_ready_expired", 32'(id));
    endtask

    task automatic send_byte(input int id, input logic [7:0] b, input logic last,
                             input logic [7:0] resp, input logic exp_rx);
        tx_q.push_back(b);
        slave_q.push_back(resp);
        if (exp_rx) rx_q.push_back({(id == 1), (id == 0), resp});
        wait_ready(id);
        if (id == 0) begin tx_dv_0 = 1'b1; tx_byte_0 = b; last_0 = last; end
        else         begin tx_dv_1 = 1'b1; tx_byte_1 = b; last_1 = last; end
        @(negedge clk);
        tx_dv_0 = 1'b0;
        tx_dv_1 = 1'b0;
    endtask

    task automatic wait_rx(input int id);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!((id == 0) ? rx_dv_0 : rx_dv_1) && cnt < 200);
        if (cnt >= 200) note_unexpected("wait_rx_expired", 32'(id));
    endtask

    // Counts negedges with CSN high between the current hold phase and the next grant.
    task automatic csn_gap(output int cnt);
        int guard = 0;
        cnt = 0;
        while (!csn && guard < 50) begin @(negedge clk); guard++; end
        while (csn && guard < 100) begin cnt++; @(negedge clk); guard++; end
        if (guard >= 100) note_unexpected("csn_gap_expired", 32'(cnt));
    endtask

    task automatic wait_idle();
        int cnt = 0;
        while (busy && cnt < 200) begin @(negedge clk); cnt++; end
        check("idle_reached", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        {req_0, tx_dv_0, last_0, req_1, tx_dv_1, last_1} = '0;
        tx_byte_0 = 8'h00;
        tx_byte_1 = 8'h00;
        spi_tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_csn", {31'd0, csn}, 32'd1);
        check("rst_gnt_busy", {28'd0, gnt_1, gnt_0, busy, timeout}, 32'd0);
        check("rst_bytes", {8'd0, tx_byte, rx_byte, 6'd0, tx_dv, rx_dv_0 | rx_dv_1}, 32'd0);
        check("rst_ready", {30'd0, tx_ready_1, tx_ready_0}, 32'd0);
        #2 rst_n = 1'b1;

        // Single requester, two bytes, second one last.
        @(negedge clk);
        req_0 = 1'b1;
        gnt_q.push_back(2'b01);
        wait_gnt(0, c);
        check("t1_first_arb_latency", 32'(c), 32'd1);
        check("t1_csn_busy", {30'd0, csn, busy}, {30'd0, 1'b0, 1'b1});
        req_0 = 1'b0;
        send_byte(0, 8'h27, 1'b0, 8'h0E, 1'b1);
        send_byte(0, 8'h70, 1'b1, 8'h00, 1'b1);
        wait_rx(0);
        @(negedge clk);
        check("t1_hold_csn_low", {31'd0, csn}, 32'd0);
        @(negedge clk);
        check("t1_csn_high_after_hold", {30'd0, csn, gnt_0}, {30'd0, 1'b1, 1'b0});
        wait_idle();

        // Both requesting from reset: round-robin 0,1,0 with foreign strobes ignored.
        do_reset(2);
        req_0 = 1'b1;
        req_1 = 1'b1;
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        gnt_q.push_back(2'b01);
        wait_gnt(0, c);
        wait_ready(0);
        check("t2_ready1_low", {31'd0, tx_ready_1}, 32'd0);
        tx_dv_1 = 1'b1; tx_byte_1 = 8'hFF; last_1 = 1'b1;
        @(negedge clk);
        tx_dv_1 = 1'b0;
        spi_tx_ready = 1'b0;
        #1 check("t2_ready_gated", {31'd0, tx_ready_0}, 32'd0);
        tx_dv_0 = 1'b1; tx_byte_0 = 8'hEE; last_0 = 1'b1;
        @(negedge clk);
        tx_dv_0 = 1'b0;
        spi_tx_ready = 1'b1;
        send_byte(0, 8'h11, 1'b1, 8'hA5, 1'b1);
        wait_rx(0);
        csn_gap(c);
        check("t2_csn_gap_0to1", 32'(c), 32'd5);
        check("t2_gnt1_after_gap", {30'd0, gnt_1, gnt_0}, 32'd2);
        req_1 = 1'b0;
        send_byte(1, 8'h22, 1'b1, 8'h5A, 1'b1);
        wait_rx(1);
        csn_gap(c);
        check("t2_csn_gap_1to0", 32'(c), 32'd5);
        req_0 = 1'b0;
        send_byte(0, 8'h7E, 1'b1, 8'hC3, 1'b1);
        wait_idle();

        // Reset while a byte is in flight, then a clean re-grant.
        req_0 = 1'b1;
        gnt_q.push_back(2'b01);
        wait_gnt(0, c);
        send_byte(0, 8'h33, 1'b0, 8'h44, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("t3_async_reset", {28'd0, csn, gnt_0, busy, tx_dv}, {28'd0, 4'b1000});
        repeat (6) @(negedge clk);
        gnt_q.push_back(2'b01);
        #2 rst_n = 1'b1;
        wait_gnt(0, c);
        check("t3_regrant_latency", 32'(c), 32'd1);
        check("t3_regrant_csn", {31'd0, csn}, 32'd0);
        req_0 = 1'b0;
        send_byte(0, 8'h55, 1'b1, 8'h66, 1'b1);
        wait_idle();

        // Granted requester stays silent.
        req_0 = 1'b1;
        gnt_q.push_back(2'b01);
        wait_gnt(0, c);
        req_0 = 1'b0;
`ifdef NRF_ARB_TIMEOUT_EN
        to_q.push_back(2'b01);
        c = 0;
        while (!timeout && c < 100) begin @(negedge clk); c++; end
        check("t4_timeout_cycle", 32'(c), 32'd18);
        @(negedge clk);
        check("t4_timeout_pulse_hold", {30'd0, timeout, csn}, 32'd0);
        @(negedge clk);
        check("t4_csn_high_after_hold", {30'd0, csn, gnt_0}, {30'd0, 2'b10});
        wait_idle();
`else
        repeat (100) @(negedge clk);
        check("t4_gnt_held", {29'd0, gnt_0, csn, timeout}, {29'd0, 3'b100});
        send_byte(0, 8'h5C, 1'b1, 8'hA3, 1'b1);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        check("queues_drained", 32'(tx_q.size() + rx_q.size() + gnt_q.size() + to_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
